// File: rtl/gates_tester.sv
// Sweeps all 256 stimulus vectors through an external gate network and counts mismatches.
// Define GATES_TESTER_FIRST_FAIL_EN to add first_fail/first_fail_vld reporting.
`timescale 1ns/1ps
module gates_tester (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [0:3] va,
    output logic [0:3] vb,
    input  logic       y,
    input  logic [0:3] vy,
    output logic       busy,
    output logic       done,
    output logic       pass,
`ifdef GATES_TESTER_FIRST_FAIL_EN
    output logic [7:0] first_fail,
    output logic       first_fail_vld,
`endif
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

    state_e     state;
    logic [7:0] idx;
    logic [7:0] stim;
    logic       exp_y;
    logic [0:3] exp_vy;
    logic       fail;
    logic [7:0] err_nxt;

    // Stimulus is only released while a vector is being driven or sampled.
    assign stim = busy ? idx : 8'h00;
    assign va   = stim[7:4];
    assign vb   = stim[3:0];
    assign a    = stim[3];
    assign b    = stim[2];
    assign c    = stim[1];
    assign d    = stim[0];

    always_comb begin
        exp_y   = (idx[3] & idx[2]) | ~(idx[1] & idx[0]);
        exp_vy  = idx[7:4] & idx[3:0];
        fail    = (y != exp_y) || (vy != exp_vy);
        err_nxt = err_cnt;
        if (fail && (err_cnt != 8'hff)) begin
            err_nxt = err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            idx            <= 8'h00;
            err_cnt        <= 8'h00;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
`ifdef GATES_TESTER_FIRST_FAIL_EN
            first_fail     <= 8'h00;
            first_fail_vld <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state          <= StDrive;
                        idx            <= 8'h00;
                        err_cnt        <= 8'h00;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
`ifdef GATES_TESTER_FIRST_FAIL_EN
                        first_fail     <= 8'h00;
                        first_fail_vld <= 1'b0;
`endif
                    end
                end
                StDrive: begin
                    state <= StSample;
                end
                StSample: begin
                    err_cnt <= err_nxt;
`ifdef GATES_TESTER_FIRST_FAIL_EN
                    if (fail && !first_fail_vld) begin
                        first_fail     <= idx;
                        first_fail_vld <= 1'b1;
                    end
`endif
                    // Last vector: stop here rather than wrapping idx into a second sweep.
                    if (idx == 8'hff) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == 8'h00);
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= StDrive;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gates_tester.sv
// Self-checking bench for gates_tester: a faultable gate network plus a per-vector reference count.
`timescale 1ns/1ps
module tb_gates_tester;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       a, b, c, d;
    logic [0:3] va, vb, vy;
    logic       y;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
`ifdef GATES_TESTER_FIRST_FAIL_EN
    logic [7:0] first_fail;
    logic       first_fail_vld;
`endif

    int         checks = 0;
    int         errors = 0;
    int         mode = 0;
    logic [4:0] flip_tab [256];
    logic [4:0] net_r;

    always #5 clk = ~clk;

    gates_tester dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .a              (a),
        .b              (b),
        .c              (c),
        .d              (d),
        .va             (va),
        .vb             (vb),
        .y              (y),
        .vy             (vy),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
`ifdef GATES_TESTER_FIRST_FAIL_EN
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld),
`endif
        .err_cnt        (err_cnt)
    );

    // Fault-free response for vector i: {y, vy[0:3]}
    function automatic logic [4:0] gold(input logic [7:0] i);
        logic ga, gb, gc, gd;
        ga = i[3]; gb = i[2]; gc = i[1]; gd = i[0];
        return {(ga & gb) | ~(gc & gd), i[7:4] & i[3:0]};
    endfunction

    function automatic logic [4:0] faulty(input int m, input logic [7:0] i, input logic [4:0] g);
        case (m)
            0:       return g;
            1:       return {1'b0, g[3:0]};
            2:       return g | 5'b01000;
            3:       return ~g;
            default: return g ^ flip_tab[i];
        endcase
    endfunction

    // Gate network under test, built from the DUT's scalar and vector stimulus
    always_comb begin
        net_r = faulty(mode, {va, vb}, {(a & b) | ~(c & d), va & vb});
    end
    assign y  = net_r[4];
    assign vy = net_r[3:0];

    task automatic model(input int m, output int e, output bit p, output int ff, output bit ffv);
        int cnt;
        cnt = 0; ff = 0; ffv = 0;
        for (int i = 0; i < 256; i++) begin
            if (faulty(m, 8'(i), gold(8'(i))) != gold(8'(i))) begin
                if (!ffv) begin ff = i; ffv = 1; end
                cnt++;
            end
        end
        e = (cnt > 255) ? 255 : cnt;
        p = (cnt == 0);
    endtask

    task automatic set_random(input int dens);
        for (int i = 0; i < 256; i++) begin
            flip_tab[i] = ($urandom_range(0, 99) < dens) ? 5'($urandom_range(1, 31)) : 5'd0;
        end
    endtask

    task automatic check_idle_zero(input string name);
        logic [7:0] st;
        st = {va, vb};
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 8'h00 ||
            st !== 8'h00 || {a, b, c, d} !== 4'h0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b pass=%b err_cnt=%0d stim=%h abcd=%b, expected all 0",
                     name, busy, done, pass, err_cnt, st, {a, b, c, d});
        end
`ifdef GATES_TESTER_FIRST_FAIL_EN
        checks++;
        if (first_fail !== 8'h00 || first_fail_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s_ff: first_fail=%h vld=%b, expected 00/0", name, first_fail,
                     first_fail_vld);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset_state");
        @(negedge clk); rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_idle_zero("idle_after_reset");
    endtask

    task automatic test_sweep(input string name, input int m, input bit poke);
        int cyc, busy_cyc, stim_bad, e, ff;
        bit p, ffv;
        logic [7:0] exp_idx, st;
        model(m, e, p, ff, ffv);
        mode = m;
        @(negedge clk); start = 1'b1;
        cyc = 0; busy_cyc = 0; stim_bad = 0;
        while (cyc < 2000) begin
            @(posedge clk); #1; cyc++;
            start = poke && (cyc == 200);
            st = {va, vb};
            if (busy) begin
                busy_cyc++;
                exp_idx = 8'((cyc - 1) / 2);
                if (st !== exp_idx || {a, b, c, d} !== exp_idx[3:0]) stim_bad++;
            end else if (st !== 8'h00 || {a, b, c, d} !== 4'h0) begin
                stim_bad++;
            end
            if (done === 1'b1) break;
        end
        start = 1'b0;
        checks++;
        if (cyc != 513) begin
            errors++;
            $display("FAIL %s_len: done after %0d cycles, expected 513", name, cyc);
        end
        checks++;
        if (busy_cyc != 512) begin
            errors++;
            $display("FAIL %s_busy: busy for %0d cycles, expected 512", name, busy_cyc);
        end
        checks++;
        if (stim_bad != 0) begin
            errors++;
            $display("FAIL %s_stim: %0d cycles with wrong stimulus, expected 0", name, stim_bad);
        end
        checks++;
        if (err_cnt !== 8'(e) || pass !== p) begin
            errors++;
            $display("FAIL %s_result: err_cnt=%0d pass=%b, expected %0d/%b", name, err_cnt, pass,
                     e, p);
        end
`ifdef GATES_TESTER_FIRST_FAIL_EN
        checks++;
        if (first_fail_vld !== ffv || first_fail !== 8'(ff)) begin
            errors++;
            $display("FAIL %s_ff: first_fail=%h vld=%b, expected %h/%b", name, first_fail,
                     first_fail_vld, 8'(ff), ffv);
        end
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err_cnt !== 8'(e) || pass !== p) begin
            errors++;
            $display("FAIL %s_hold: done=%b busy=%b err_cnt=%0d pass=%b, expected 1/0/%0d/%b",
                     name, done, busy, err_cnt, pass, e, p);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        mode = 3;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 1;
        while (cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        #2; rst = 1'b1;
        #1;
        check_idle_zero("mid_reset_async");
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_idle_zero("mid_reset_idle");
        test_sweep("after_reset", 0, 1'b0);
    endtask

    task automatic test_start_held();
        int cyc, e, ff;
        bit p, ffv;
        model(1, e, p, ff, ffv);
        mode = 1;
        @(negedge clk); start = 1'b1;
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk); #1; cyc++;
            if (done === 1'b1) break;
        end
        checks++;
        if (cyc != 513 || err_cnt !== 8'(e)) begin
            errors++;
            $display("FAIL held_first: done after %0d cycles err_cnt=%0d, expected 513/%0d", cyc,
                     err_cnt, e);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL held_restart: done=%b busy=%b err_cnt=%0d, expected 0/1/0", done, busy,
                     err_cnt);
        end
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk); #1; cyc++;
            if (done === 1'b1) break;
        end
        start = 1'b0;
        checks++;
        if (cyc != 512 || err_cnt !== 8'(e) || pass !== p) begin
            errors++;
            $display("FAIL held_second: done after %0d cycles err_cnt=%0d pass=%b, expected 512/%0d/%b",
                     cyc, err_cnt, pass, e, p);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) flip_tab[i] = 5'd0;
        test_reset();
        test_sweep("ref_ok", 0, 1'b0);
        test_sweep("y_stuck0", 1, 1'b0);
        test_sweep("vy0_stuck1", 2, 1'b1);
        test_sweep("inverted", 3, 1'b0);
        set_random(20);
        test_sweep("rand_sparse", 4, 1'b1);
        set_random(90);
        test_sweep("rand_dense", 4, 1'b0);
        test_mid_reset();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
